// File: rtl/bus_uart_pkg.sv
// Shared definitions for the bus_uart peripheral: register map, STATUS bit
// positions, serial FSM state encoding and the divisor clamp helper.
package bus_uart_pkg;

  // Word index within the block (bus_addr).
  localparam logic [1:0] RegTx   = 2'd0;
  localparam logic [1:0] RegRx   = 2'd1;
  localparam logic [1:0] RegStat = 2'd2;
  localparam logic [1:0] RegDiv  = 2'd3;

  // STATUS register bit positions.
  localparam int unsigned StatTxFull   = 0;
  localparam int unsigned StatTxBusy   = 1;
  localparam int unsigned StatRxValid  = 2;
  localparam int unsigned StatOverrun  = 3;
  localparam int unsigned StatFrameErr = 4;
  localparam int unsigned StatTxIrqEn  = 5;
  localparam int unsigned StatWidth    = 6;

  // Both serial FSMs walk the same frame shape.
  typedef enum logic [1:0] {
    Idle  = 2'd0,
    Start = 2'd1,
    Data  = 2'd2,
    Stop  = 2'd3
  } uart_state_e;

  typedef uart_state_e tx_state_e;
  typedef uart_state_e rx_state_e;

  // The half-bit wait of the receiver needs at least two clocks per bit.
  function automatic logic [15:0] clamp_div(input logic [15:0] value);
    return (value < 16'd2) ? 16'd2 : value;
  endfunction

endpackage

// File: rtl/bus_uart_fifo.sv
// Synchronous FIFO with combinational head read. Full/empty come from
// read/write pointers carrying one extra wrap bit. A push into a full FIFO
// is accepted when a pop happens in the same cycle.
module bus_uart_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         data_w,
  output logic [WIDTH-1:0]         data_r,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign data_r  = mem[rd_ptr[AW-1:0]];

  // Pointer update on accepted push/pop.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write.
  // NOTE: the array is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= data_w;
  end

endmodule

// File: rtl/bus_uart.sv
// Memory-mapped UART: TX FIFO, single-entry RX holding register, STATUS and
// baud divisor registers on a word-addressed bus with registered read data.
// Build option: define BUS_UART_RX_EN to include the receiver; without it
// rxd is ignored and all RX state reads as 0.
module bus_uart
  import bus_uart_pkg::*;
#(
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sel,
  input  logic [1:0]  bus_addr,
  input  logic [31:0] bus_data_w,
  input  logic [3:0]  bus_mask_w,
  output logic [31:0] bus_data_r,
  output logic        txd,
  input  logic        rxd,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                  wr, wr_tx, wr_rx, wr_stat, wr_div;
  logic [15:0]           div;
  logic                  tx_irq_en;
  logic                  fifo_full, fifo_empty, tx_pop;
  logic [7:0]            fifo_head;
  logic [CW-1:0]         fifo_count;
  logic [15:0]           tx_count;
  logic                  tx_busy;
  logic                  rx_valid, overrun, frame_err;
  logic [7:0]            rx_byte;
  logic [StatWidth-1:0]  status;
  logic [31:0]           rd_word;
  logic                  unused_ok;

  tx_state_e   tx_state, tx_state_n;
  logic [15:0] tx_cnt, tx_cnt_n;
  logic [2:0]  tx_bit, tx_bit_n;
  logic [7:0]  tx_shift, tx_shift_n;
  logic        txd_n;

  assign wr      = sel & (|bus_mask_w);
  assign wr_tx   = wr & (bus_addr == RegTx) & bus_mask_w[0];
  assign wr_rx   = wr & (bus_addr == RegRx);
  assign wr_stat = wr & (bus_addr == RegStat) & bus_mask_w[0];
  assign wr_div  = wr & (bus_addr == RegDiv) & (bus_mask_w[1:0] == 2'b11);

  // Divisor and TX interrupt enable registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      div       <= 16'(CLK_DIV);
      tx_irq_en <= 1'b0;
    end else begin
      if (wr_div)  div       <= clamp_div(bus_data_w[15:0]);
      if (wr_stat) tx_irq_en <= bus_data_w[StatTxIrqEn];
    end
  end

  bus_uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clock  (clock),
    .reset  (reset),
    .push   (wr_tx),
    .pop    (tx_pop),
    .data_w (bus_data_w[7:0]),
    .data_r (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign tx_count = 16'(fifo_count);
  assign tx_busy  = (tx_state != Idle) | (tx_count != 16'd0);

  // TX next state: each state lasts div clocks counted down from div-1, so a
  // new divisor is picked up when the next bit period is loaded.
  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    txd_n      = txd;
    tx_pop     = 1'b0;
    unique case (tx_state)
      Idle: begin
        txd_n = 1'b1;
        if (!fifo_empty) begin
          tx_pop     = 1'b1;
          tx_shift_n = fifo_head;
          tx_cnt_n   = div - 16'd1;
          tx_state_n = Start;
          txd_n      = 1'b0;
        end
      end
      Start: begin
        if (tx_cnt == 16'd0) begin
          tx_state_n = Data;
          tx_bit_n   = 3'd0;
          tx_cnt_n   = div - 16'd1;
          txd_n      = tx_shift[0];
        end else begin
          tx_cnt_n = tx_cnt - 16'd1;
        end
      end
      Data: begin
        if (tx_cnt == 16'd0) begin
          tx_cnt_n = div - 16'd1;
          if (tx_bit == 3'd7) begin
            tx_state_n = Stop;
            txd_n      = 1'b1;
          end else begin
            tx_bit_n   = tx_bit + 3'd1;
            tx_shift_n = tx_shift >> 1;
            txd_n      = tx_shift[1];
          end
        end else begin
          tx_cnt_n = tx_cnt - 16'd1;
        end
      end
      Stop: begin
        if (tx_cnt == 16'd0) tx_state_n = Idle;
        else                 tx_cnt_n   = tx_cnt - 16'd1;
      end
      default: tx_state_n = Idle;
    endcase
  end

  // TX state register; txd is registered so the line never glitches.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state <= Idle;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      txd      <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      txd      <= txd_n;
    end
  end

`ifdef BUS_UART_RX_EN
  logic [1:0]  rx_sync;
  logic        rx_s, rx_done;
  rx_state_e   rx_state, rx_state_n;
  logic [15:0] rx_cnt, rx_cnt_n;
  logic [2:0]  rx_bit, rx_bit_n;
  logic [7:0]  rx_shift, rx_shift_n;

  assign rx_s = rx_sync[1];

  // Two-flop synchronizer for the asynchronous serial input (idles high).
  always_ff @(posedge clock) begin
    if (reset) rx_sync <= 2'b11;
    else       rx_sync <= {rx_sync[0], rxd};
  end

  // RX next state: Start is the half-bit confirmation of the start bit; data
  // and stop are then sampled at whole-bit intervals from that midpoint.
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_done    = 1'b0;
    unique case (rx_state)
      Idle: begin
        if (!rx_s) begin
          rx_state_n = Start;
          rx_cnt_n   = (div >> 1) - 16'd1;
        end
      end
      Start: begin
        if (rx_cnt == 16'd0) begin
          if (!rx_s) begin
            rx_state_n = Data;
            rx_bit_n   = 3'd0;
            rx_cnt_n   = div - 16'd1;
          end else begin
            rx_state_n = Idle;
          end
        end else begin
          rx_cnt_n = rx_cnt - 16'd1;
        end
      end
      Data: begin
        if (rx_cnt == 16'd0) begin
          rx_shift_n = {rx_s, rx_shift[7:1]};
          rx_cnt_n   = div - 16'd1;
          if (rx_bit == 3'd7) rx_state_n = Stop;
          else                rx_bit_n   = rx_bit + 3'd1;
        end else begin
          rx_cnt_n = rx_cnt - 16'd1;
        end
      end
      Stop: begin
        if (rx_cnt == 16'd0) begin
          rx_done    = 1'b1;
          rx_state_n = Idle;
        end else begin
          rx_cnt_n = rx_cnt - 16'd1;
        end
      end
      default: rx_state_n = Idle;
    endcase
  end

  // RX state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state <= Idle;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end

  // Holding register and error flags: software pop/clear first, hardware
  // events last so they win a same-cycle collision.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_valid  <= 1'b0;
      rx_byte   <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= rx_valid & ~wr_rx;
      overrun   <= overrun & ~(wr_stat & bus_data_w[StatOverrun]);
      frame_err <= frame_err & ~(wr_stat & bus_data_w[StatFrameErr]);
      if (rx_done) begin
        if (!rx_s) begin
          frame_err <= 1'b1;
        end else if (rx_valid & ~wr_rx) begin
          overrun <= 1'b1;
        end else begin
          rx_byte  <= rx_shift;
          rx_valid <= 1'b1;
        end
      end
    end
  end

  assign unused_ok = &{1'b0, bus_data_w[31:16]};
`else
  assign rx_valid  = 1'b0;
  assign overrun   = 1'b0;
  assign frame_err = 1'b0;
  assign rx_byte   = 8'h00;
  assign unused_ok = &{1'b0, bus_data_w[31:16], rxd};
`endif

  assign status[StatTxFull]   = fifo_full;
  assign status[StatTxBusy]   = tx_busy;
  assign status[StatRxValid]  = rx_valid;
  assign status[StatOverrun]  = overrun;
  assign status[StatFrameErr] = frame_err;
  assign status[StatTxIrqEn]  = tx_irq_en;

  // Side-effect-free read mux.
  always_comb begin
    rd_word = '0;
    unique case (bus_addr)
      RegTx:   rd_word = {16'b0, tx_count};
      RegRx:   rd_word = {rx_valid, 23'b0, rx_byte};
      RegStat: rd_word = {{(32 - StatWidth){1'b0}}, status};
      RegDiv:  rd_word = {16'b0, div};
      default: rd_word = '0;
    endcase
  end

  // Registered read data and interrupt.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus_data_r <= '0;
      irq        <= 1'b0;
    end else begin
      bus_data_r <= sel ? rd_word : 32'h0;
      irq        <= rx_valid | (fifo_empty & tx_irq_en);
    end
  end

endmodule

// File: tb/tb_bus_uart.sv
// Directed self-checking bench for bus_uart. Inputs change on the falling
// edge; outputs are sampled on the falling edge. The RX section follows the
// BUS_UART_RX_EN build option of the design.
`timescale 1ns/1ps
module tb_bus_uart;
  import bus_uart_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        sel;
  logic [1:0]  bus_addr;
  logic [31:0] bus_data_w;
  logic [3:0]  bus_mask_w;
  logic [31:0] bus_data_r;
  logic        txd;
  logic        rxd;
  logic        irq;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  bus_uart dut (
    .clock      (clock),
    .reset      (reset),
    .sel        (sel),
    .bus_addr   (bus_addr),
    .bus_data_w (bus_data_w),
    .bus_mask_w (bus_mask_w),
    .bus_data_r (bus_data_r),
    .txd        (txd),
    .rxd        (rxd),
    .irq        (irq)
  );

  initial begin
    #1ms;
    $display("FAIL watchdog: observed no end of test, required finish within 1 ms");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] m);
    sel = 1'b1; bus_addr = a; bus_data_w = d; bus_mask_w = m;
    @(negedge clock);
    sel = 1'b0; bus_mask_w = 4'h0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    sel = 1'b1; bus_addr = a; bus_mask_w = 4'h0;
    @(negedge clock);
    d = bus_data_r;
    sel = 1'b0;
  endtask

  // Drive one 4-clock-per-bit frame on rxd, then 8 idle clocks.
  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    repeat (4) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (4) @(negedge clock);
    end
    rxd = stop_bit;
    repeat (4) @(negedge clock);
    rxd = 1'b1;
    repeat (8) @(negedge clock);
  endtask

  // Decode one frame from txd. k=0 is the first low sample; bit i spans
  // k = div*(i+1) .. div*(i+2)-1 and is sampled near its middle.
  task automatic uart_capture(input int div_v, output logic [7:0] b, output logic ok);
    int n = 0;
    int k = 0;
    b  = 8'h00;
    ok = 1'b0;
    while (txd !== 1'b0 && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (txd === 1'b0) begin
      for (int i = 0; i < 8; i++) begin
        while (k < div_v * (i + 1) + (div_v - 1) / 2) begin
          @(negedge clock);
          k++;
        end
        b[i] = txd;
      end
      while (k < div_v * 9 + (div_v - 1) / 2) begin
        @(negedge clock);
        k++;
      end
      ok = (txd === 1'b1);
    end
  endtask

  logic [31:0] rd;
  logic        found;
  logic        txd_log  [44];
  logic        busy_log [44];
  logic [7:0]  frame;
  logic [7:0]  pat      [18];
  logic [7:0]  got      [17];
  logic        stop_ok  [17];

  initial begin
    reset = 1'b1; sel = 1'b0; bus_addr = 2'd0; bus_data_w = '0; bus_mask_w = 4'h0; rxd = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Reset state.
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_rdata", bus_data_r, 32'd0);
    bus_read(RegDiv, rd);  check("rst_div", rd, 32'd868);
    sel = 1'b0; bus_addr = RegDiv;
    @(negedge clock);      check("unselected_read", bus_data_r, 32'd0);
    bus_read(RegStat, rd); check("rst_status", rd, 32'd0);
    bus_read(RegTx, rd);   check("rst_txcount", rd, 32'd0);
    bus_read(RegRx, rd);   check("rst_rxdata", rd, 32'd0);

    // TX-empty interrupt enable.
    bus_write(RegStat, 32'h20, 4'h1);
    @(negedge clock);      check("irq_tx_empty", 32'(irq), 32'd1);
    bus_read(RegStat, rd); check("status_irq_en", rd, 32'h20);
    bus_write(RegStat, 32'h00, 4'h1);
    @(negedge clock);      check("irq_off", 32'(irq), 32'd0);

    // Divisor clamp and partial-mask write.
    bus_write(RegDiv, 32'h1, 4'h3);
    bus_read(RegDiv, rd);  check("div_clamp", rd, 32'd2);
    bus_write(RegDiv, 32'h9, 4'h1);
    bus_read(RegDiv, rd);  check("div_mask_ignored", rd, 32'd2);
    bus_write(RegDiv, 32'h4, 4'h3);
    bus_read(RegDiv, rd);  check("div_load", rd, 32'd4);

    // One frame of 0xA5 at 4 clocks/bit, watching STATUS.tx_busy throughout.
    bus_write(RegTx, 32'hA5, 4'h1);
    sel = 1'b1; bus_addr = RegStat; bus_mask_w = 4'h0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      if (txd === 1'b0) found = 1'b1;
    end
    check("tx_start_seen", 32'(found), 32'd1);
    for (int k = 0; k < 44; k++) begin
      txd_log[k]  = txd;
      busy_log[k] = bus_data_r[StatTxBusy];
      @(negedge clock);
    end
    sel = 1'b0;
    frame = 8'hA5;
    for (int k = 0; k < 44; k++) begin
      if (k < 4)       check($sformatf("tx_a5_start_k%0d", k), 32'(txd_log[k]), 32'd0);
      else if (k < 36) check($sformatf("tx_a5_bit_k%0d", k), 32'(txd_log[k]), 32'(frame[(k - 4) / 4]));
      else             check($sformatf("tx_a5_stop_k%0d", k), 32'(txd_log[k]), 32'd1);
      check($sformatf("tx_busy_k%0d", k), 32'(busy_log[k]), (k <= 40) ? 32'd1 : 32'd0);
    end
    bus_read(RegTx, rd);   check("tx_count_drained", rd, 32'd0);

    // FIFO fill at 2 clocks/bit: the first byte leaves the FIFO one cycle
    // after it lands, so 18 pushes fill 16 entries and drop the last one.
    bus_write(RegDiv, 32'h2, 4'h3);
    for (int i = 0; i < 18; i++) pat[i] = 8'(i * 37 + 3);
    fork
      begin
        logic [31:0] r;
        for (int i = 0; i < 18; i++) bus_write(RegTx, {24'b0, pat[i]}, 4'h1);
        bus_read(RegTx, r);   check("fifo_count_full", r, 32'd16);
        bus_read(RegStat, r); check("fifo_full_flag", 32'(r[StatTxFull]), 32'd1);
      end
      begin
        for (int j = 0; j < 17; j++) uart_capture(2, got[j], stop_ok[j]);
      end
    join
    for (int j = 0; j < 17; j++) begin
      check($sformatf("fifo_byte%0d", j), 32'(got[j]), 32'(pat[j]));
      check($sformatf("fifo_stop%0d", j), 32'(stop_ok[j]), 32'd1);
    end
    repeat (4) @(negedge clock);
    bus_read(RegStat, rd); check("fifo_done_status", rd, 32'd0);

    // Receiver at 4 clocks/bit.
    bus_write(RegDiv, 32'h4, 4'h3);
`ifdef BUS_UART_RX_EN
    send_rx(8'h3C, 1'b1);
    check("rx_irq", 32'(irq), 32'd1);
    bus_read(RegRx, rd);   check("rx_byte", rd, 32'h8000003C);
    bus_read(RegRx, rd);   check("rx_read_no_pop", rd, 32'h8000003C);
    send_rx(8'h5A, 1'b1);
    bus_read(RegStat, rd); check("rx_overrun", rd, 32'h0C);
    bus_read(RegRx, rd);   check("rx_kept_old", rd, 32'h8000003C);
    bus_write(RegStat, 32'h08, 4'h1);
    bus_read(RegStat, rd); check("rx_overrun_clr", rd, 32'h04);
    bus_write(RegRx, 32'h0, 4'h1);
    bus_read(RegRx, rd);   check("rx_popped", rd, 32'h0000003C);
    check("rx_irq_clr", 32'(irq), 32'd0);
    send_rx(8'h81, 1'b0);
    bus_read(RegStat, rd); check("rx_frame_err", rd, 32'h10);
    bus_read(RegRx, rd);   check("rx_frame_no_byte", rd, 32'h0000003C);
    bus_write(RegStat, 32'h10, 4'h1);
    bus_read(RegStat, rd); check("rx_frame_err_clr", rd, 32'h0);
    rxd = 1'b0;
    @(negedge clock);
    rxd = 1'b1;
    repeat (50) @(negedge clock);
    bus_read(RegStat, rd); check("rx_glitch_status", rd, 32'h0);
    bus_read(RegRx, rd);   check("rx_glitch_rxdata", rd, 32'h0000003C);
    // Pop landing on the same edge as the next byte's stop sample.
    send_rx(8'hC3, 1'b1);
    fork
      send_rx(8'h96, 1'b1);
      begin
        repeat (40) @(negedge clock);
        bus_write(RegRx, 32'h0, 4'h1);
      end
    join
    bus_read(RegRx, rd);   check("rx_pop_same_cycle", rd, 32'h80000096);
    bus_read(RegStat, rd); check("rx_pop_no_overrun", rd, 32'h04);
    bus_write(RegRx, 32'h0, 4'h1);
`else
    send_rx(8'h3C, 1'b1);
    bus_read(RegRx, rd);   check("rx_off_rxdata", rd, 32'h0);
    bus_read(RegStat, rd); check("rx_off_status", rd, 32'h0);
    check("rx_off_irq", 32'(irq), 32'd0);
`endif

    // Reset in the middle of data bit 3 with a byte still queued.
    bus_write(RegTx, 32'hA5, 4'h1);
    bus_write(RegTx, 32'h11, 4'h1);
    begin
      int n = 0;
      while (txd !== 1'b0 && n < 20) begin
        @(negedge clock);
        n++;
      end
    end
    check("rst_mid_start", 32'(txd), 32'd0);
    repeat (17) @(negedge clock);
    check("rst_mid_bit3", 32'(txd), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check("rst_mid_txd", 32'(txd), 32'd1);
    reset = 1'b0;
    bus_read(RegTx, rd);   check("rst_mid_count", rd, 32'd0);
    bus_read(RegDiv, rd);  check("rst_mid_div", rd, 32'd868);
    bus_read(RegStat, rd); check("rst_mid_status", rd, 32'd0);
    repeat (5) @(negedge clock);
    check("rst_mid_idle", 32'(txd), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
